// File: rtl/vga_pixel_out.sv
// vga_pixel_out: final VGA output stage.
// Owns the raster counters that every drawing object sees. Delays the raw
// sync/blank timing so it meets the pixel coming back from the draw+mux
// pipeline, and expands RGB332 to the 8-bit-per-channel DAC.
// Pixel handshake: none. RGBIn is sampled on every clk edge, and the value
// present must belong to the coordinate that was published PIPE_DELAY cycles
// earlier. There is no valid or ready.
module vga_pixel_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN,
    output logic        syncN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Bit positions inside one timing word {active, hs_raw, vs_raw}.
    localparam int T_ACT = 2;
    localparam int T_HS  = 1;
    localparam int T_VS  = 0;
    // Blanked, both syncs de-asserted (high).
    localparam logic [2:0] TIMING_IDLE = 3'b011;

    // The raster holds at (0,0) for one cycle after reset. That way the first
    // frame-start pulse lines up with (0,0) on the cycle after resetN rises.
    logic        started_q, started_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        sof_q, sof_d;

    logic [2:0]                  raw_timing;
    logic [PIPE_DELAY-1:0][2:0]  pipe_q, pipe_d;
    logic [2:0]                  tap;

    logic [7:0] red_q, red_d;
    logic [7:0] green_q, green_d;
    logic [7:0] blue_q, blue_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       sync_q;

    // Next raster position and the frame-start flag for that position.
    always_comb begin
        started_d = 1'b1;
        x_d       = x_q;
        y_d       = y_q;
        if (started_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end
        sof_d = (x_d == '0) && (y_d == '0);
    end

    // Raster counter and frame-start registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            started_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            sof_q     <= 1'b0;
        end else begin
            started_q <= started_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sof_q     <= sof_d;
        end
    end

    // Undelayed timing for the coordinate currently published.
    always_comb begin
        raw_timing        = TIMING_IDLE;
        raw_timing[T_ACT] = (x_q < H_ACT) && (y_q < V_ACT);
        raw_timing[T_HS]  = !((x_q >= HS_START) && (x_q < HS_END));
        raw_timing[T_VS]  = !((y_q >= VS_START) && (y_q < VS_END));
    end

    // Shift the timing word one stage per clock.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = raw_timing;
        for (int i = 1; i < PIPE_DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Timing delay line, matching the draw+mux latency.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pipe_q <= {PIPE_DELAY{TIMING_IDLE}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tap = pipe_q[PIPE_DELAY-1];

    // Colour expansion by bit replication, forced black outside active video.
    always_comb begin
        blank_d = tap[T_ACT];
        hs_d    = tap[T_HS];
        vs_d    = tap[T_VS];
        red_d   = 8'h00;
        green_d = 8'h00;
        blue_d  = 8'h00;
        if (tap[T_ACT]) begin
            red_d   = {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]};
            green_d = {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]};
            blue_d  = {RGBIn[1:0], RGBIn[1:0], RGBIn[1:0], RGBIn[1:0]};
        end
    end

    // DAC output register: the pixel and its delayed timing leave together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            red_q   <= 8'h00;
            green_q <= 8'h00;
            blue_q  <= 8'h00;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            sync_q  <= 1'b0;
        end
    end

    assign pixelX       = x_q;
    assign pixelY       = y_q;
    assign startOfFrame = sof_q;
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign hSync        = hs_q;
    assign vSync        = vs_q;
    assign blankN       = blank_q;
    assign syncN        = sync_q;

endmodule
